read_buffer: RTL and testbench

Read-side counterpart of the accelerator's write buffer. Accepts 32-bit word read requests from the datapath, fetches whole cache lines over the CCI read request/response channel, holds the most recent line in a one-line buffer, and serves word hits from it without a memory round trip. Sits between the datapath's read port and the CCI read channel, alongside the write buffer that drives the write channel.

---
 rtl/read_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_read_buffer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/read_buffer.sv
// read_buffer: one-line read cache in front of the CCI read channel.
// Serves 32-bit word reads from the most recently fetched cache line and
// fetches whole lines on a miss, a direct read, or after an invalidate.
module read_buffer #(
    parameter int ADDR_LMT    = 20,
    parameter int MDATA       = 14,
    parameter int CACHE_WIDTH = 512,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                              clk,
    input  logic                                              rst,
    // CCI read request channel
    output logic [ADDR_LMT-1:0]                               rd_req_addr,
    output logic [MDATA-1:0]                                  rd_req_mdata,
    output logic                                              rd_req_en,
    input  logic                                              rd_req_almostfull,
    // CCI read response channel
    input  logic                                              rd_rsp_valid,
    input  logic [MDATA-1:0]                                  rd_rsp_mdata,
    input  logic [CACHE_WIDTH-1:0]                            rd_rsp_data,
    // Datapath read port
    input  logic                                              rd_en,
    input  logic [ADDR_LMT+$clog2(CACHE_WIDTH/DATA_WIDTH)-1:0] rd_addr,
    input  logic                                              rd_direct,
    input  logic                                              invalidate,
    output logic                                              rd_valid,
    output logic [DATA_WIDTH-1:0]                             rd_data,
    output logic [CACHE_WIDTH-1:0]                            rd_line,
    output logic                                              rd_busy,
    input  logic                                              start
);

    localparam int WORDS = CACHE_WIDTH / DATA_WIDTH;
    localparam int OFF_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_REQ   = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    // Controller state
    state_e                  state_q,       state_d;
    logic                    line_valid_q,  line_valid_d;
    logic [ADDR_LMT-1:0]     line_tag_q,    line_tag_d;
    logic [CACHE_WIDTH-1:0]  line_q,        line_d;
    logic [MDATA-1:0]        tag_ctr_q,     tag_ctr_d;
    logic [ADDR_LMT-1:0]     pend_line_q,   pend_line_d;
    logic [OFF_W-1:0]        pend_off_q,    pend_off_d;
    // Set when invalidate arrives while a fetch is outstanding: the returning
    // line may already be stale, so it is handed to the client but not kept.
    logic                    inval_seen_q,  inval_seen_d;

    // Registered outputs
    logic [ADDR_LMT-1:0]     rd_req_addr_q,  rd_req_addr_d;
    logic [MDATA-1:0]        rd_req_mdata_q, rd_req_mdata_d;
    logic                    rd_req_en_q,    rd_req_en_d;
    logic                    rd_valid_q,     rd_valid_d;
    logic [DATA_WIDTH-1:0]   rd_data_q,      rd_data_d;
    logic [CACHE_WIDTH-1:0]  rd_line_q,      rd_line_d;

    // Address split and word-indexed views of the stored and returned lines
    logic [ADDR_LMT-1:0]                 req_line;
    logic [OFF_W-1:0]                    req_off;
    logic [WORDS-1:0][DATA_WIDTH-1:0]    line_words;
    logic [WORDS-1:0][DATA_WIDTH-1:0]    rsp_words;
    logic                                hit;
    logic                                rsp_match;

    assign req_line   = rd_addr[ADDR_LMT+OFF_W-1:OFF_W];
    assign req_off    = rd_addr[OFF_W-1:0];
    assign line_words = line_q;
    assign rsp_words  = rd_rsp_data;

    // An invalidate in the same cycle wins over the hit.
    assign hit       = line_valid_q && (line_tag_q == req_line) && !rd_direct && !invalidate;
    // The last issued tag is held in rd_req_mdata_q, so it doubles as the match key.
    assign rsp_match = rd_rsp_valid && (rd_rsp_mdata == rd_req_mdata_q);

    // Next-state and output computation for the read controller
    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no path through
        // the case below leaves one unassigned, which would infer a latch.
        state_d        = state_q;
        line_valid_d   = line_valid_q;
        line_tag_d     = line_tag_q;
        line_d         = line_q;
        tag_ctr_d      = tag_ctr_q;
        pend_line_d    = pend_line_q;
        pend_off_d     = pend_off_q;
        inval_seen_d   = inval_seen_q;
        rd_req_addr_d  = rd_req_addr_q;
        rd_req_mdata_d = rd_req_mdata_q;
        rd_req_en_d    = 1'b0;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        rd_line_d      = rd_line_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READY;
                end
            end

            S_READY: begin
                if (invalidate) begin
                    line_valid_d = 1'b0;
                end
                if (rd_en) begin
                    if (hit) begin
                        rd_data_d  = line_words[req_off];
                        rd_line_d  = line_q;
                        rd_valid_d = 1'b1;
                    end else begin
                        pend_line_d = req_line;
                        pend_off_d  = req_off;
                        state_d     = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (invalidate) begin
                    line_valid_d = 1'b0;
                end
                if (!rd_req_almostfull) begin
                    rd_req_addr_d  = pend_line_q;
                    rd_req_mdata_d = tag_ctr_q;
                    rd_req_en_d    = 1'b1;
                    tag_ctr_d      = tag_ctr_q + 1'b1;
                    inval_seen_d   = 1'b0;
                    state_d        = S_WAIT;
                end
            end

            S_WAIT: begin
                if (invalidate) begin
                    line_valid_d = 1'b0;
                    inval_seen_d = 1'b1;
                end
                if (rsp_match) begin
                    line_d       = rd_rsp_data;
                    line_tag_d   = pend_line_q;
                    line_valid_d = !(inval_seen_q || invalidate);
                    rd_data_d    = rsp_words[pend_off_q];
                    rd_line_d    = rd_rsp_data;
                    rd_valid_d   = 1'b1;
                    state_d      = S_READY;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            line_valid_q   <= 1'b0;
            line_tag_q     <= '0;
            // NOTE: the line buffer is reset as well so rd_line never exposes
            // undefined data; it is a single register, not a RAM.
            line_q         <= '0;
            tag_ctr_q      <= '0;
            pend_line_q    <= '0;
            pend_off_q     <= '0;
            inval_seen_q   <= 1'b0;
            rd_req_addr_q  <= '0;
            rd_req_mdata_q <= '0;
            rd_req_en_q    <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_line_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed from the previous cycle's state.
            state_q        <= state_d;
            line_valid_q   <= line_valid_d;
            line_tag_q     <= line_tag_d;
            line_q         <= line_d;
            tag_ctr_q      <= tag_ctr_d;
            pend_line_q    <= pend_line_d;
            pend_off_q     <= pend_off_d;
            inval_seen_q   <= inval_seen_d;
            rd_req_addr_q  <= rd_req_addr_d;
            rd_req_mdata_q <= rd_req_mdata_d;
            rd_req_en_q    <= rd_req_en_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_line_q      <= rd_line_d;
        end
    end

    assign rd_req_addr  = rd_req_addr_q;
    assign rd_req_mdata = rd_req_mdata_q;
    assign rd_req_en    = rd_req_en_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_line      = rd_line_q;
    assign rd_busy      = (state_q != S_READY);

endmodule

// File: tb/tb_read_buffer.sv
// tb_read_buffer: directed self-checking bench for read_buffer.
module tb_read_buffer;

    localparam int ADDR_LMT    = 20;
    localparam int MDATA       = 14;
    localparam int CACHE_WIDTH = 512;
    localparam int DATA_WIDTH  = 32;
    localparam int AW          = ADDR_LMT + 4;

    logic                   clk;
    logic                   rst;
    logic [ADDR_LMT-1:0]    rd_req_addr;
    logic [MDATA-1:0]       rd_req_mdata;
    logic                   rd_req_en;
    logic                   rd_req_almostfull;
    logic                   rd_rsp_valid;
    logic [MDATA-1:0]       rd_rsp_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;
    logic                   rd_en;
    logic [AW-1:0]          rd_addr;
    logic                   rd_direct;
    logic                   invalidate;
    logic                   rd_valid;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic [CACHE_WIDTH-1:0] rd_line;
    logic                   rd_busy;
    logic                   start;

    int checks = 0;
    int errors = 0;

    read_buffer #(
        .ADDR_LMT(ADDR_LMT), .MDATA(MDATA),
        .CACHE_WIDTH(CACHE_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull),
        .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_direct(rd_direct), .invalidate(invalidate),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_line(rd_line), .rd_busy(rd_busy),
        .start(start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [CACHE_WIDTH-1:0] got,
                         input logic [CACHE_WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line whose word k holds base+k
    function automatic logic [CACHE_WIDTH-1:0] mk_line(input logic [31:0] base);
        logic [CACHE_WIDTH-1:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    // Miss with an immediate response; exact cycle timing is checked
    task automatic miss(input string tag, input logic [AW-1:0] addr, input logic direct,
                        input logic inv, input logic [31:0] base,
                        input logic [MDATA-1:0] exp_tag, input logic [31:0] exp_word);
        rd_addr = addr; rd_direct = direct; invalidate = inv; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rd_direct = 1'b0; invalidate = 1'b0;
        check({tag, "_busy_req"}, rd_busy, 1);
        check({tag, "_noearly"}, rd_req_en, 0);
        tick();
        check({tag, "_req_en"}, rd_req_en, 1);
        check({tag, "_req_addr"}, rd_req_addr, addr[AW-1:4]);
        check({tag, "_req_mdata"}, rd_req_mdata, exp_tag);
        rd_rsp_valid = 1'b1; rd_rsp_mdata = exp_tag; rd_rsp_data = mk_line(base);
        tick();
        rd_rsp_valid = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp_word);
        check({tag, "_line"}, rd_line, mk_line(base));
        check({tag, "_req_pulse"}, rd_req_en, 0);
        check({tag, "_ready"}, rd_busy, 0);
    endtask

    // Hit: rd_valid in the cycle after rd_en, no fetch
    task automatic hit(input string tag, input logic [AW-1:0] addr,
                       input logic [31:0] base, input logic [31:0] exp_word);
        rd_addr = addr; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, rd_valid, 1);
        check({tag, "_data"}, rd_data, exp_word);
        check({tag, "_line"}, rd_line, mk_line(base));
        check({tag, "_noreq"}, rd_req_en, 0);
        check({tag, "_ready"}, rd_busy, 0);
    endtask

    // Bulk direct fetch with bounded wait; returns 0 if the request never came
    task automatic quiet_fetch(output bit ok);
        ok = 1'b0;
        rd_addr = 24'h80; rd_direct = 1'b1; rd_en = 1'b1;
        tick();
        rd_en = 1'b0; rd_direct = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (rd_req_en) ok = 1'b1;
        end
        if (!ok) begin
            check("bulk_req_timeout", 0, 1);
        end else begin
            rd_rsp_valid = 1'b1; rd_rsp_mdata = rd_req_mdata; rd_rsp_data = '0;
            tick();
            rd_rsp_valid = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        rst = 1'b0; start = 1'b0; rd_req_almostfull = 1'b0;
        rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_direct = 1'b0; invalidate = 1'b0;

        // Reset values
        #20;
        check("rst_busy", rd_busy, 1);
        check("rst_req_en", rd_req_en, 0);
        check("rst_req_addr", rd_req_addr, 0);
        check("rst_req_mdata", rd_req_mdata, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_line", rd_line, 0);
        rst = 1'b1;
        tick();
        check("idle_busy", rd_busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ready", rd_busy, 0);

        // First miss, then hits on the same line
        miss("miss0", 24'h35, 1'b0, 1'b0, 32'h100, 14'd0, 32'h105);
        hit("hit0", 24'h3F, 32'h100, 32'h10F);
        hit("hit1", 24'h30, 32'h100, 32'h100);
        tick();
        check("hit_pulse", rd_valid, 0);

        // almostfull holds REQ for five cycles
        rd_req_almostfull = 1'b1;
        rd_addr = 24'h72; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("af_hold", rd_req_en, 0);
        end
        rd_req_almostfull = 1'b0;
        tick();
        check("af_req_en", rd_req_en, 1);
        check("af_req_addr", rd_req_addr, 20'h7);
        check("af_req_mdata", rd_req_mdata, 14'd1);
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'd1; rd_rsp_data = mk_line(32'h200);
        tick();
        rd_rsp_valid = 1'b0;
        check("af_valid", rd_valid, 1);
        check("af_data", rd_data, 32'h202);
        check("af_req_pulse", rd_req_en, 0);

        // Wrong tag ignored, invalidate during WAIT
        rd_addr = 24'h52; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("wt_req_mdata", rd_req_mdata, 14'd2);
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'd7; rd_rsp_data = mk_line(32'h300);
        tick();
        rd_rsp_valid = 1'b0;
        check("wt_ignored", rd_valid, 0);
        check("wt_busy", rd_busy, 1);
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        check("wt_inv_novalid", rd_valid, 0);
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'd2;
        tick();
        rd_rsp_valid = 1'b0;
        check("wt_valid", rd_valid, 1);
        check("wt_data", rd_data, 32'h302);
        check("wt_ready", rd_busy, 0);
        miss("refetch", 24'h57, 1'b0, 1'b0, 32'h400, 14'd3, 32'h407);
        hit("refetch_hit", 24'h5C, 32'h400, 32'h40C);

        // invalidate in the same cycle as a would-be hit forces a miss
        miss("inv_prio", 24'h5A, 1'b0, 1'b1, 32'h500, 14'd4, 32'h50A);
        hit("inv_prio_hit", 24'h51, 32'h500, 32'h501);

        // rd_direct on a buffered line refetches
        miss("direct", 24'h51, 1'b1, 1'b0, 32'h600, 14'd5, 32'h601);

        // Run the tag counter up to its last value, then check the wrap
        for (int n = 6; n < (1 << MDATA); n++) begin
            quiet_fetch(ok);
            if (!ok) break;
        end
        miss("wrap0", 24'h93, 1'b0, 1'b0, 32'h700, 14'd0, 32'h703);
        miss("wrap1", 24'h93, 1'b1, 1'b0, 32'h800, 14'd1, 32'h803);

        // Reset while a fetch is outstanding
        rd_addr = 24'hA4; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        check("mr_req_en", rd_req_en, 1);
        check("mr_req_mdata", rd_req_mdata, 14'd2);
        rst = 1'b0;
        #2;
        check("mr_busy", rd_busy, 1);
        check("mr_req_en0", rd_req_en, 0);
        check("mr_mdata0", rd_req_mdata, 0);
        check("mr_addr0", rd_req_addr, 0);
        check("mr_line0", rd_line, 0);
        #2;
        rst = 1'b1;
        tick();
        check("mr_idle", rd_busy, 1);
        rd_rsp_valid = 1'b1; rd_rsp_mdata = 14'd2; rd_rsp_data = mk_line(32'h999);
        tick();
        rd_rsp_valid = 1'b0;
        check("mr_rsp_idle", rd_valid, 0);
        check("mr_still_idle", rd_busy, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mr_start", rd_busy, 0);
        rd_rsp_valid = 1'b1;
        tick();
        rd_rsp_valid = 1'b0;
        check("mr_rsp_ready", rd_valid, 0);
        miss("post_rst", 24'hA4, 1'b0, 1'b0, 32'h900, 14'd0, 32'h904);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
